// File: rtl/ram_loader.sv
// Bus-master loader that fills program RAM from a byte stream while holding the CPU in clear.
// Sequences one MAR-in and one RAM-in bus cycle per accepted byte.
module ram_loader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RAM_LENGTH = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  i_CLOCK,
  input  logic                  i_CLEAR,
  input  logic                  i_START,
  input  logic                  i_ABORT,
  input  logic [DATA_WIDTH-1:0] i_DATA,
  input  logic                  i_VALID,
  output logic                  o_READY,
  output logic [DATA_WIDTH-1:0] o_BUS,
  output logic                  o_BUS_DRIVE,
  output logic                  o_MAR_IN,
  output logic                  o_RAM_IN,
  output logic                  o_CPU_HOLD,
  output logic                  o_BUSY,
  output logic                  o_DONE,
  output logic [ADDR_WIDTH-1:0] o_ADDR
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_DATA = 3'd1;
  localparam logic [2:0] MAR_WRITE = 3'd2;
  localparam logic [2:0] RAM_WRITE = 3'd3;
  localparam logic [2:0] FINISH    = 3'd4;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_LENGTH - 1);

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] addr_ext;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    // Abort beats every other transition, including byte capture.
    if (i_ABORT && (state_q != IDLE)) begin
      state_d = IDLE;
      addr_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_START) begin
            state_d = WAIT_DATA;
            addr_d  = '0;
          end
        end
        WAIT_DATA: begin
          if (i_VALID) begin
            data_d  = i_DATA;
            state_d = MAR_WRITE;
          end
        end
        MAR_WRITE: state_d = RAM_WRITE;
        RAM_WRITE: begin
          // Counter parks on the last address instead of wrapping.
          if (addr_q == LAST_ADDR) begin
            state_d = FINISH;
          end else begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            state_d = WAIT_DATA;
          end
        end
        FINISH:  state_d = IDLE;
        default: begin
          state_d = IDLE;
          addr_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_CLOCK or posedge i_CLEAR) begin
    if (i_CLEAR) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    addr_ext                   = '0;
    addr_ext[ADDR_WIDTH-1:0]   = addr_q;
  end

  // All strobes decode from registered state only, so a clear drops them immediately.
  always_comb begin
    o_READY     = 1'b0;
    o_BUS       = '0;
    o_BUS_DRIVE = 1'b0;
    o_MAR_IN    = 1'b0;
    o_RAM_IN    = 1'b0;
    o_CPU_HOLD  = 1'b0;
    o_BUSY      = 1'b0;
    o_DONE      = 1'b0;
    case (state_q)
      WAIT_DATA: begin
        o_READY    = 1'b1;
        o_CPU_HOLD = 1'b1;
        o_BUSY     = 1'b1;
      end
      MAR_WRITE: begin
        o_BUS       = addr_ext;
        o_BUS_DRIVE = 1'b1;
        o_MAR_IN    = 1'b1;
        o_CPU_HOLD  = 1'b1;
        o_BUSY      = 1'b1;
      end
      RAM_WRITE: begin
        o_BUS       = data_q;
        o_BUS_DRIVE = 1'b1;
        o_RAM_IN    = 1'b1;
        o_CPU_HOLD  = 1'b1;
        o_BUSY      = 1'b1;
      end
      FINISH: begin
        o_DONE     = 1'b1;
        o_CPU_HOLD = 1'b1;
        o_BUSY     = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_ADDR = addr_q;

endmodule

// File: tb/tb_ram_loader.sv
// Randomized scoreboard bench for ram_loader: the driver queues the (address, byte) writes a
// correct loader must make; a negedge monitor pops them as RAM-in strobes appear.
module tb_ram_loader;

  localparam int DW  = 8;
  localparam int LEN = 16;
  localparam int AW  = 4;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort_s;
  logic [DW-1:0] din;
  logic          valid;
  logic          ready;
  logic [DW-1:0] bus;
  logic          bus_drive;
  logic          mar_in;
  logic          ram_in;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic [AW-1:0] addr;

  ram_loader #(
    .DATA_WIDTH(DW),
    .RAM_LENGTH(LEN),
    .ADDR_WIDTH(AW)
  ) dut (
    .i_CLOCK    (clk),
    .i_CLEAR    (rst),
    .i_START    (start),
    .i_ABORT    (abort_s),
    .i_DATA     (din),
    .i_VALID    (valid),
    .o_READY    (ready),
    .o_BUS      (bus),
    .o_BUS_DRIVE(bus_drive),
    .o_MAR_IN   (mar_in),
    .o_RAM_IN   (ram_in),
    .o_CPU_HOLD (cpu_hold),
    .o_BUSY     (busy),
    .o_DONE     (done),
    .o_ADDR     (addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_pass   = 0;
  int            done_cnt = 0;
  wr_t           exp_q[$];
  logic [DW-1:0] bytes[LEN];
  logic [DW-1:0] mem[LEN];
  int            wr_cnt[LEN];
  logic [AW-1:0] mar_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: bus protocol every cycle, and scoreboard pop on each RAM write.
  initial begin
    wr_t e;
    mar_addr = '0;
    forever begin
      @(negedge clk);
      check("mar_ram_exclusive", 32'(mar_in & ram_in), 32'd0);
      check("drive_eq_strobe", 32'(bus_drive), 32'(mar_in | ram_in));
      if (!bus_drive) check("bus_zero_when_idle", 32'(bus), 32'd0);
      if (ready)
        check("wait_outputs", 32'({mar_in, ram_in, bus_drive, done, cpu_hold, busy}),
              32'b000011);
      if (mar_in) mar_addr = bus[AW-1:0];
      if (ram_in) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_write: actual write to %0h with %0h required none",
                   mar_addr, bus);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", 32'(mar_addr), 32'(e.a));
          check("write_data", 32'(bus), 32'(e.d));
        end
        mem[mar_addr] = bus;
        wr_cnt[mar_addr]++;
      end
      if (done) done_cnt++;
    end
  end

  // mode 0: valid always, 1: every 5th cycle, 2: random. Model: k-th accepted byte -> address k.
  task automatic run_load(input int mode, input bit spam, input int budget, output int done_cyc);
    int cyc;
    int idx;
    cyc      = 0;
    idx      = 0;
    done_cyc = -1;
    for (int a = 0; a < LEN; a++) wr_cnt[a] = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    while (done_cyc < 0 && cyc < budget) begin
      case (mode)
        0:       valid = 1'b1;
        1:       valid = (cyc % 5 == 0);
        default: valid = ($urandom_range(0, 2) != 0);
      endcase
      din = bytes[(idx < LEN) ? idx : LEN - 1];
      if (spam) start = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (ready && valid) begin
        exp_q.push_back('{a: AW'(idx), d: din});
        idx++;
      end
      if (done) begin
        done_cyc = cyc;
        if (spam) start = 1'b1;
      end
      step();
      cyc++;
    end
    valid = 1'b0;
    start = 1'b0;
    check("load_completes", 32'(done_cyc >= 0), 32'd1);
    check("hold_low_after_done", 32'(cpu_hold), 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);
    check("bytes_accepted", 32'(idx), 32'(LEN));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    for (int a = 0; a < LEN; a++) begin
      check("write_once", 32'(wr_cnt[a]), 32'd1);
      check("ram_content", 32'(mem[a]), 32'(bytes[a]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    int d0;
    int idx;
    bit hit;
    rst     = 1'b1;
    start   = 1'b0;
    abort_s = 1'b0;
    din     = '0;
    valid   = 1'b0;
    for (int a = 0; a < LEN; a++) mem[a] = '0;
    #1;
    check("reset_outputs",
          32'({ready, bus_drive, mar_in, ram_in, cpu_hold, busy, done}), 32'd0);
    check("reset_bus", 32'(bus), 32'd0);
    check("reset_addr", 32'(addr), 32'd0);
    step();
    rst = 1'b0;
    step();

    // 1: full-rate load of 0x10..0x1F.
    for (int a = 0; a < LEN; a++) bytes[a] = 8'(8'h10 + a);
    d0 = done_cnt;
    run_load(0, 1'b0, 200, dc);
    check("done_latency_cycles", 32'(dc + 1), 32'(3 * LEN + 1));
    check("done_once", 32'(done_cnt - d0), 32'd1);

    // 2: throttled source.
    for (int a = 0; a < LEN; a++) bytes[a] = 8'($urandom);
    run_load(1, 1'b0, 400, dc);

    // 3: abort during the RAM write of address 3.
    for (int a = 0; a < LEN; a++) begin
      bytes[a]  = 8'($urandom);
      wr_cnt[a] = 0;
    end
    d0  = done_cnt;
    idx = 0;
    hit = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      valid = 1'b1;
      din   = bytes[idx];
      @(negedge clk);
      if (ready && valid) begin
        exp_q.push_back('{a: AW'(idx), d: din});
        idx++;
      end
      if (ram_in && idx == 4) begin
        abort_s = 1'b1;
        hit     = 1'b1;
      end
      step();
    end
    abort_s = 1'b0;
    valid   = 1'b0;
    check("abort_reached", 32'(hit), 32'd1);
    check("abort_idle", 32'(busy), 32'd0);
    check("abort_hold", 32'(cpu_hold), 32'd0);
    check("abort_addr", 32'(addr), 32'd0);
    check("abort_write3_done", 32'(wr_cnt[3]), 32'd1);
    check("abort_write3_data", 32'(mem[3]), 32'(bytes[3]));
    check("abort_no_write4", 32'(wr_cnt[4]), 32'd0);
    repeat (3) step();
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_stays_idle", 32'(busy), 32'd0);
    abort_s = 1'b1;
    step();
    abort_s = 1'b0;
    check("abort_in_idle_noop", 32'({busy, addr}), 32'd0);

    // 4: asynchronous clear in the middle of a MAR write.
    for (int a = 0; a < LEN; a++) bytes[a] = 8'($urandom);
    idx = 0;
    hit = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      valid = 1'b1;
      din   = bytes[idx];
      @(negedge clk);
      if (ready && valid) begin
        exp_q.push_back('{a: AW'(idx), d: din});
        idx++;
      end
      if (mar_in && idx == 3) begin
        hit = 1'b1;
        #2;
        rst = 1'b1;
        #1;
      end else begin
        step();
      end
    end
    valid = 1'b0;
    check("clear_reached", 32'(hit), 32'd1);
    check("clear_strobes", 32'({mar_in, bus_drive, cpu_hold, busy}), 32'd0);
    check("clear_bus", 32'(bus), 32'd0);
    exp_q.delete();
    step();
    rst = 1'b0;
    step();
    check("clear_idle", 32'({busy, ready}), 32'd0);
    check("clear_addr", 32'(addr), 32'd0);

    // 5: start spammed during the load and in the FINISH cycle.
    for (int a = 0; a < LEN; a++) bytes[a] = 8'($urandom);
    run_load(0, 1'b1, 200, dc);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stay_idle_after_finish", 32'(busy), 32'd0);
      step();
    end

    // 6: random-valid run under the protocol monitor.
    for (int a = 0; a < LEN; a++) bytes[a] = 8'($urandom);
    run_load(2, 1'b0, 400, dc);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
